// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the fetch PC, issues word reads to instruction
// memory and buffers a returned word while the pipeline is stalled.
module if_fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        IF_Stall,
  input  logic        IF_Exception_Stall,
  input  logic        IF_Exception_Flush,
  input  logic [31:0] IF_PCIn,
  input  logic        ID_BranchOrJump,
  input  logic [31:0] ID_PC,
  input  logic        InstMem_Ready,
  input  logic [31:0] InstMem_Data,
  output logic        InstMem_Read,
  output logic [29:0] InstMem_Address,
  output logic [31:0] IF_PCOut,
  output logic [31:0] IF_PCAdd4,
  output logic [31:0] IF_Instruction,
  output logic        IF_IsBDS,
  output logic [31:0] IF_PC_PreExc,
  output logic        IF_EXC_AdIF,
  output logic        IF_Fetch_Stall
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 30;
  localparam logic [DATA_W-1:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic {FETCH, HOLD} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              misaligned;
  logic              advance;

  assign misaligned = (pc_q[1:0] != 2'b00);

  // State, PC and instruction buffer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Memory handshake, instruction select and next-state
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    buf_d          = buf_q;
    InstMem_Read   = 1'b0;
    IF_Fetch_Stall = 1'b0;
    IF_Instruction = '0;
    advance        = 1'b0;

    if (!reset && !misaligned) begin
      if (state_q == FETCH) begin
        InstMem_Read   = ~IF_Exception_Flush;
        IF_Fetch_Stall = ~IF_Exception_Flush & ~InstMem_Ready;
        if (!IF_Exception_Flush && InstMem_Ready) begin
          IF_Instruction = InstMem_Data;
        end
      end else begin
        IF_Instruction = buf_q;
      end
    end

    advance = ~IF_Stall & ~IF_Exception_Stall & ~IF_Fetch_Stall;

    // A flush redirects unconditionally and drops whatever was buffered
    if (IF_Exception_Flush) begin
      pc_d    = IF_PCIn;
      buf_d   = '0;
      state_d = FETCH;
    end else if (state_q == HOLD) begin
      if (advance) begin
        pc_d    = IF_PCIn;
        state_d = FETCH;
      end
    end else if (misaligned) begin
      if (advance) begin
        pc_d = IF_PCIn;
      end
    end else if (InstMem_Ready) begin
      if (advance) begin
        pc_d = IF_PCIn;
      end else begin
        buf_d   = InstMem_Data;
        state_d = HOLD;
      end
    end
  end

  assign InstMem_Address = pc_q[DATA_W-1 -: ADDR_W];
  assign IF_PCOut        = pc_q;
  assign IF_PCAdd4       = pc_q + DATA_W'(4);
  assign IF_EXC_AdIF     = misaligned & ~reset;
  assign IF_IsBDS        = ID_BranchOrJump & ~reset;
  assign IF_PC_PreExc    = IF_IsBDS ? ID_PC : pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming fetch, memory wait, stall/HOLD,
// misaligned fetch, exception flush, PC wrap, branch delay slot and reset.
module tb_if_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        IF_Stall, IF_Exception_Stall, IF_Exception_Flush;
  logic [31:0] IF_PCIn;
  logic        ID_BranchOrJump;
  logic [31:0] ID_PC;
  logic        InstMem_Ready;
  logic [31:0] InstMem_Data;
  logic        InstMem_Read;
  logic [29:0] InstMem_Address;
  logic [31:0] IF_PCOut, IF_PCAdd4, IF_Instruction, IF_PC_PreExc;
  logic        IF_IsBDS, IF_EXC_AdIF, IF_Fetch_Stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  if_fetch_unit dut (
    .clock              (clock),
    .reset              (reset),
    .IF_Stall           (IF_Stall),
    .IF_Exception_Stall (IF_Exception_Stall),
    .IF_Exception_Flush (IF_Exception_Flush),
    .IF_PCIn            (IF_PCIn),
    .ID_BranchOrJump    (ID_BranchOrJump),
    .ID_PC              (ID_PC),
    .InstMem_Ready      (InstMem_Ready),
    .InstMem_Data       (InstMem_Data),
    .InstMem_Read       (InstMem_Read),
    .InstMem_Address    (InstMem_Address),
    .IF_PCOut           (IF_PCOut),
    .IF_PCAdd4          (IF_PCAdd4),
    .IF_Instruction     (IF_Instruction),
    .IF_IsBDS           (IF_IsBDS),
    .IF_PC_PreExc       (IF_PC_PreExc),
    .IF_EXC_AdIF        (IF_EXC_AdIF),
    .IF_Fetch_Stall     (IF_Fetch_Stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let inputs and outputs settle.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Checks for a normal aligned fetch cycle.
  task automatic chk_fetch(input string tag, input logic [29:0] addr,
                           input logic rd, input logic stall, input logic [31:0] inst);
    chk({tag, ".addr"},  32'(addr), 32'(InstMem_Address));
    chk({tag, ".read"},  32'(InstMem_Read), 32'(rd));
    chk({tag, ".stall"}, 32'(IF_Fetch_Stall), 32'(stall));
    chk({tag, ".inst"},  IF_Instruction, inst);
  endtask

  initial begin
    reset = 1'b1; IF_Stall = 1'b0; IF_Exception_Stall = 1'b0; IF_Exception_Flush = 1'b0;
    IF_PCIn = 32'h0; ID_BranchOrJump = 1'b1; ID_PC = 32'h1234_5678;
    InstMem_Ready = 1'b0; InstMem_Data = 32'hAAAA_0000;
    #2;
    // Reset cycle: outputs quiet, BDS masked
    chk("rst.read",  32'(InstMem_Read), 32'd0);
    chk("rst.inst",  IF_Instruction, 32'd0);
    chk("rst.bds",   32'(IF_IsBDS), 32'd0);
    chk("rst.adif",  32'(IF_EXC_AdIF), 32'd0);
    chk("rst.stall", 32'(IF_Fetch_Stall), 32'd0);
    tick();
    chk("rst.pc", IF_PCOut, 32'hBFC0_0000);

    // Streaming fetch, one word per cycle
    reset = 1'b0; ID_BranchOrJump = 1'b0;
    InstMem_Ready = 1'b1; InstMem_Data = 32'h1111_1111; IF_PCIn = 32'hBFC0_0004;
    #1;
    chk_fetch("s0", 30'h2FF0_0000, 1'b1, 1'b0, 32'h1111_1111);
    chk("s0.add4", IF_PCAdd4, 32'hBFC0_0004);
    tick();
    InstMem_Data = 32'h2222_2222; IF_PCIn = 32'hBFC0_0008;
    #1;
    chk_fetch("s1", 30'h2FF0_0001, 1'b1, 1'b0, 32'h2222_2222);
    tick();

    // Memory wait of three cycles
    InstMem_Ready = 1'b0; InstMem_Data = 32'h3333_3333; IF_PCIn = 32'hBFC0_000C;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_fetch("wait", 30'h2FF0_0002, 1'b1, 1'b1, 32'h0);
      tick();
    end
    InstMem_Ready = 1'b1;
    #1;
    chk_fetch("wait.done", 30'h2FF0_0002, 1'b1, 1'b0, 32'h3333_3333);
    tick();
    chk("wait.pc", IF_PCOut, 32'hBFC0_000C);

    // Data returns while stalled: buffer it, no re-read
    IF_Stall = 1'b1; InstMem_Data = 32'h4444_4444; IF_PCIn = 32'hBFC0_0010;
    #1;
    chk_fetch("hold.cap", 30'h2FF0_0003, 1'b1, 1'b0, 32'h4444_4444);
    tick();
    InstMem_Data = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_fetch("hold", 30'h2FF0_0003, 1'b0, 1'b0, 32'h4444_4444);
      tick();
    end
    IF_Stall = 1'b0; InstMem_Ready = 1'b0;
    #1;
    chk_fetch("hold.rel", 30'h2FF0_0003, 1'b0, 1'b0, 32'h4444_4444);
    tick();
    chk("hold.pc", IF_PCOut, 32'hBFC0_0010);
    #1;
    chk_fetch("hold.refetch", 30'h2FF0_0004, 1'b1, 1'b1, 32'h0);

    // Misaligned redirect
    InstMem_Ready = 1'b1; InstMem_Data = 32'h5555_5555; IF_PCIn = 32'h8000_0002;
    tick();
    IF_PCIn = 32'hBFC0_0014;
    #1;
    chk("mis.adif",  32'(IF_EXC_AdIF), 32'd1);
    chk("mis.read",  32'(InstMem_Read), 32'd0);
    chk("mis.inst",  IF_Instruction, 32'h0);
    chk("mis.stall", 32'(IF_Fetch_Stall), 32'd0);
    tick();
    chk("mis.pc",   IF_PCOut, 32'hBFC0_0014);
    chk("mis.adif0", 32'(IF_EXC_AdIF), 32'd0);

    // Flush from HOLD discards the buffer
    IF_Stall = 1'b1; InstMem_Data = 32'h6666_6666;
    tick();
    IF_Exception_Flush = 1'b1; IF_Exception_Stall = 1'b1; IF_PCIn = 32'h8000_0180;
    #1;
    chk("fl.hold.read", 32'(InstMem_Read), 32'd0);
    tick();
    IF_Exception_Flush = 1'b0; IF_Exception_Stall = 1'b0; InstMem_Ready = 1'b0;
    #1;
    chk("fl.pc", IF_PCOut, 32'h8000_0180);
    chk_fetch("fl.fetch", 30'h2000_0060, 1'b1, 1'b1, 32'h0);

    // Flush abandons an outstanding request; redirect to the top word
    IF_Exception_Flush = 1'b1; IF_PCIn = 32'hFFFF_FFFC;
    #1;
    chk("fl.abandon.read",  32'(InstMem_Read), 32'd0);
    chk("fl.abandon.stall", 32'(IF_Fetch_Stall), 32'd0);
    tick();
    IF_Exception_Flush = 1'b0;
    #1;
    chk("wrap.pc",   IF_PCOut, 32'hFFFF_FFFC);
    chk("wrap.add4", IF_PCAdd4, 32'h0000_0000);
    chk("wrap.addr", 32'(InstMem_Address), 32'h3FFF_FFFF);

    // Branch delay slot selection of the restart PC
    ID_BranchOrJump = 1'b1; ID_PC = 32'hBFC0_0010;
    #1;
    chk("bds.flag", 32'(IF_IsBDS), 32'd1);
    chk("bds.epc",  IF_PC_PreExc, 32'hBFC0_0010);
    ID_BranchOrJump = 1'b0;
    #1;
    chk("nobds.flag", 32'(IF_IsBDS), 32'd0);
    chk("nobds.epc",  IF_PC_PreExc, 32'hFFFF_FFFC);

    // Reset while holding a buffered word
    InstMem_Ready = 1'b1; InstMem_Data = 32'h7777_7777;
    tick();
    reset = 1'b1;
    #1;
    chk("rst.hold.read", 32'(InstMem_Read), 32'd0);
    chk("rst.hold.inst", IF_Instruction, 32'h0);
    tick();
    reset = 1'b0; IF_Stall = 1'b0; InstMem_Ready = 1'b0;
    #1;
    chk("rst2.pc", IF_PCOut, 32'hBFC0_0000);
    chk_fetch("rst2", 30'h2FF0_0000, 1'b1, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Ports SHALL be: clock  in  1  sole clock, rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled only on rising clock.
REQ-003 IF_Stall  in  1  hazard-unit stall of IF/ID.
REQ-004 IF_Exception_Stall  in  1  exception-unit stall.
REQ-005 IF_Exception_Flush  in  1  exception redirect; IF_PCIn carries vector.
REQ-006 IF_PCIn  in  32  next PC selected by ID/exception logic.
REQ-007 ID_BranchOrJump  in  1  instruction now in ID is branch/jump.
REQ-008 ID_PC  in  32  PC of instruction now in ID.
REQ-009 InstMem_Ready  in  1  memory read data valid this cycle.
REQ-010 InstMem_Data  in  32  memory read data.
REQ-011 InstMem_Read  out  1  level read request.
REQ-012 InstMem_Address  out  30  word address = PC[31:2].
REQ-013 IF_PCOut  out  32  current fetch PC.
REQ-014 IF_PCAdd4  out  32  IF_PCOut + 4, mod 2^32.
REQ-015 IF_Instruction  out  32  fetched word, or 0 (NOP) when none valid.
REQ-016 IF_IsBDS  out  1  fetched instruction is a branch delay slot.
REQ-017 IF_PC_PreExc  out  32  restart PC for EPC.
REQ-018 IF_EXC_AdIF  out  1  misaligned-fetch address error.
REQ-019 IF_Fetch_Stall  out  1  IF waiting on memory; stalls pipeline.

Function
REQ-020 Internal state: PC reg (32), instruction buffer (32), FSM {FETCH, HOLD}.
REQ-021 Advance SHALL equal ~IF_Stall & ~IF_Exception_Stall & ~IF_Fetch_Stall.
REQ-022 misaligned SHALL equal PC[1:0] != 0; IF_EXC_AdIF = misaligned.
REQ-023 FETCH: InstMem_Read = ~misaligned & ~IF_Exception_Flush; address stable while Read high.
REQ-024 FETCH, aligned, Ready=0: IF_Fetch_Stall=1, IF_Instruction=0, PC held.
REQ-025 FETCH, Ready=1, Advance: IF_Instruction=InstMem_Data same cycle (0 latency); PC<=IF_PCIn; stay FETCH.
REQ-026 FETCH, Ready=1, not Advance: buffer<=InstMem_Data; go HOLD.
REQ-027 HOLD: InstMem_Read=0, IF_Fetch_Stall=0, IF_Instruction=buffer; on Advance PC<=IF_PCIn and go FETCH; no memory re-read.
REQ-028 Misaligned (any state): InstMem_Read=0, IF_Fetch_Stall=0, IF_Instruction=0; PC updates on Advance as normal.
REQ-029 IF_Exception_Flush SHALL have top priority: PC<=IF_PCIn, buffer discarded, next state FETCH, regardless of stalls; any outstanding request is abandoned by deasserting InstMem_Read that cycle.
REQ-030 Ready when Read=0 SHALL be ignored.
REQ-031 IF_IsBDS = ID_BranchOrJump & ~reset (combinational).
REQ-032 IF_PC_PreExc = IF_IsBDS ? ID_PC : IF_PCOut.
REQ-033 PC wraps 0xFFFFFFFC+4 -> 0x00000000; no overflow flag.

Reset
REQ-034 On reset: PC<=0xBFC00000, buffer<=0, state<=FETCH.
REQ-035 During reset cycle: InstMem_Read=0, IF_Instruction=0, IF_IsBDS=0, IF_EXC_AdIF=0, IF_Fetch_Stall=0.
REQ-036 Reset mid-request or in HOLD SHALL drop request and buffer; first request issued the cycle after reset deasserts.

Verification
REQ-037 Release reset, Ready=1 every cycle, IF_PCIn=PCAdd4 -> addresses 0x2FF00000,0x2FF00001,...; one instruction per cycle.
REQ-038 Ready delayed 3 cycles -> IF_Fetch_Stall=1 and IF_Instruction=0 for 3 cycles, PC held, data passed on 4th.
REQ-039 Ready=1 while IF_Stall=1 for 2 cycles -> HOLD, Read=0, IF_Instruction=buffered word, single memory read total.
REQ-040 IF_PCIn=0x80000002 -> next cycle IF_EXC_AdIF=1, Read=0, IF_Instruction=0.
REQ-041 IF_Exception_Flush in HOLD with IF_PCIn=0x80000180 -> next PC 0x80000180, FETCH, buffer discarded.
REQ-042 ID_BranchOrJump=1, ID_PC=0xBFC00010 -> IF_IsBDS=1, IF_PC_PreExc=0xBFC00010.
